// File: rtl/e203_icb_rr_arbiter.sv
// Two-requester ICB arbiter: round-robin grant, combinational command path,
// in-order response return to the owning requester, ownership locked while
// transactions are outstanding.
module e203_icb_rr_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned OUTS_CNT = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i0_icb_cmd_valid,
  output logic              i0_icb_cmd_ready,
  input  logic [AW-1:0]     i0_icb_cmd_addr,
  input  logic              i0_icb_cmd_read,
  input  logic [DW-1:0]     i0_icb_cmd_wdata,
  input  logic [DW/8-1:0]   i0_icb_cmd_wmask,
  output logic              i0_icb_rsp_valid,
  input  logic              i0_icb_rsp_ready,
  output logic              i0_icb_rsp_err,
  output logic [DW-1:0]     i0_icb_rsp_rdata,

  input  logic              i1_icb_cmd_valid,
  output logic              i1_icb_cmd_ready,
  input  logic [AW-1:0]     i1_icb_cmd_addr,
  input  logic              i1_icb_cmd_read,
  input  logic [DW-1:0]     i1_icb_cmd_wdata,
  input  logic [DW/8-1:0]   i1_icb_cmd_wmask,
  output logic              i1_icb_rsp_valid,
  input  logic              i1_icb_rsp_ready,
  output logic              i1_icb_rsp_err,
  output logic [DW-1:0]     i1_icb_rsp_rdata,

  output logic              o_icb_cmd_valid,
  input  logic              o_icb_cmd_ready,
  output logic [AW-1:0]     o_icb_cmd_addr,
  output logic              o_icb_cmd_read,
  output logic [DW-1:0]     o_icb_cmd_wdata,
  output logic [DW/8-1:0]   o_icb_cmd_wmask,
  input  logic              o_icb_rsp_valid,
  output logic              o_icb_rsp_ready,
  input  logic              o_icb_rsp_err,
  input  logic [DW-1:0]     o_icb_rsp_rdata
);

  localparam int unsigned MW = DW / 8;
  localparam int unsigned CW = $clog2(OUTS_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(OUTS_CNT);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          read;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } cmd_t;

  logic          own;
  logic [CW-1:0] outs_cnt;
  logic          hold_vld;
  logic          hold_sel;

  logic          sel;
  logic          en;
  logic          cmd_hs;
  logic          rsp_hs;
  cmd_t          cmd0;
  cmd_t          cmd1;
  cmd_t          cmd_sel;

  assign cmd0 = '{addr: i0_icb_cmd_addr, read: i0_icb_cmd_read,
                  wdata: i0_icb_cmd_wdata, wmask: i0_icb_cmd_wmask};
  assign cmd1 = '{addr: i1_icb_cmd_addr, read: i1_icb_cmd_read,
                  wdata: i1_icb_cmd_wdata, wmask: i1_icb_cmd_wmask};

  // Grant selection: stall lock first, then owner lock, then round-robin.
  always_comb begin
    sel = own;
    if (hold_vld) begin
      sel = hold_sel;
    end else if (outs_cnt != '0) begin
      sel = own;
    end else if (i0_icb_cmd_valid && !i1_icb_cmd_valid) begin
      sel = 1'b0;
    end else if (i1_icb_cmd_valid && !i0_icb_cmd_valid) begin
      sel = 1'b1;
    end else if (i0_icb_cmd_valid && i1_icb_cmd_valid) begin
      sel = ~own;
    end
  end

  // Command path: issue enable, valid/ready and payload mux.
  always_comb begin
    en               = (outs_cnt < CNT_MAX) && ((outs_cnt == '0) || (sel == own));
    cmd_sel          = sel ? cmd1 : cmd0;
    o_icb_cmd_valid  = en && (sel ? i1_icb_cmd_valid : i0_icb_cmd_valid);
    o_icb_cmd_addr   = cmd_sel.addr;
    o_icb_cmd_read   = cmd_sel.read;
    o_icb_cmd_wdata  = cmd_sel.wdata;
    o_icb_cmd_wmask  = cmd_sel.wmask;
    i0_icb_cmd_ready = !sel && en && o_icb_cmd_ready;
    i1_icb_cmd_ready =  sel && en && o_icb_cmd_ready;
    cmd_hs           = o_icb_cmd_valid && o_icb_cmd_ready;
  end

  // Response path: valid and ready steered by the current owner.
  always_comb begin
    i0_icb_rsp_valid = !own && o_icb_rsp_valid;
    i1_icb_rsp_valid =  own && o_icb_rsp_valid;
    i0_icb_rsp_err   = o_icb_rsp_err;
    i1_icb_rsp_err   = o_icb_rsp_err;
    i0_icb_rsp_rdata = o_icb_rsp_rdata;
    i1_icb_rsp_rdata = o_icb_rsp_rdata;
    o_icb_rsp_ready  = own ? i1_icb_rsp_ready : i0_icb_rsp_ready;
    rsp_hs           = o_icb_rsp_valid && o_icb_rsp_ready;
  end

  // Ownership, stall lock and outstanding-transaction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own      <= 1'b1;
      outs_cnt <= '0;
      hold_vld <= 1'b0;
      hold_sel <= 1'b0;
    end else begin
      hold_vld <= o_icb_cmd_valid && !o_icb_cmd_ready;
      hold_sel <= sel;
      if (cmd_hs) begin
        own <= sel;
      end
      if (cmd_hs && !rsp_hs) begin
        outs_cnt <= outs_cnt + CW'(1);
      end else if (rsp_hs && !cmd_hs && (outs_cnt != '0)) begin
        outs_cnt <= outs_cnt - CW'(1);
      end
    end
  end

endmodule
